// File: rtl/serial_and_pkg.sv
// rtl/serial_and_pkg.sv - shared types and defaults for the serial AND engine
package serial_and_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/and_bit_cell.sv
// rtl/and_bit_cell.sv - one-bit AND built as a 2:1 mux (d0=0, d1=a, sel=b)
module and_bit_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    logic d0;
    logic d1;
    logic sel;

    assign d0  = 1'b0;
    assign d1  = a;
    assign sel = b;

    // 2:1 mux: passes a when b is set, otherwise zero
    always_comb begin
        y = d0;
        if (sel) begin
            y = d1;
        end
    end

endmodule

// File: rtl/serial_and_engine.sv
// rtl/serial_and_engine.sv - bit-serial AND engine with valid/ready handshakes
module serial_and_engine
    import serial_and_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   y_sr;
    logic               res_bit;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = in_valid && (state == IDLE);
    assign out_fire = out_ready && (state == DONE);

    and_bit_cell u_cell (
        .a (a_sr[0]),
        .b (b_sr[0]),
        .y (res_bit)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode and handshake outputs; stray encodings fall back to IDLE
    always_comb begin
        state_nxt = IDLE;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                busy      = 1'b0;
                state_nxt = in_fire ? SHIFT : IDLE;
            end
            SHIFT: begin
                state_nxt = (cnt == LAST_IDX) ? DONE : SHIFT;
            end
            DONE: begin
                out_valid = 1'b1;
                state_nxt = out_fire ? IDLE : DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // operand capture and one-bit-per-edge shifting into the result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            a_sr <= '0;
            b_sr <= '0;
            y_sr <= '0;
        end else if (in_fire) begin
            cnt  <= '0;
            a_sr <= in_a;
            b_sr <= in_b;
        end else if (state == SHIFT) begin
            cnt  <= cnt + CNT_W'(1);
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            y_sr <= {res_bit, y_sr[WIDTH-1:1]};
        end
    end

    assign out_y = y_sr;

endmodule

// File: tb/tb_serial_and_engine.sv
// tb/tb_serial_and_engine.sv - directed self-checking bench for serial_and_engine
module tb_serial_and_engine;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         busy;

    int total;
    int bad;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        bit         toggle;
        int         hold;
    } vec_t;

    vec_t vecs[6];

    serial_and_engine #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] y,
                          input bit toggle, input int hold);
        int  e;
        bit  got;
        @(negedge clk);
        chk("in_ready_before_op", in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        e   = 0;
        got = 0;
        while (!got && e < 40) begin
            @(negedge clk);
            if (out_valid) begin
                got      = 1;
                in_valid = 1'b0;
            end else begin
                if (toggle) begin
                    in_a     = ~in_a;
                    in_b     = 8'($urandom);
                    in_valid = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk);
                e++;
            end
        end
        chk("out_valid_seen", 32'(got), 1);
        chk("latency", 32'(e), W);
        chk("out_y", 32'(out_y), 32'(y));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_out_y", 32'(out_y), 32'(y));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", 32'(out_valid), 0);
        chk("post_in_ready", 32'(in_ready), 1);
        chk("post_busy", 32'(busy), 0);
    endtask

    initial begin
        int e;
        int nin;
        int nout;
        int in_edge[3];
        int out_edge[3];
        logic [7:0] bb_a[3];
        logic [7:0] bb_b[3];
        logic [7:0] bb_y[3];
        bit saw_valid;

        total = 0;
        bad   = 0;

        vecs[0] = '{8'hF0, 8'h3C, 8'h30, 1'b0, 0};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 1'b0, 0};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 0};
        vecs[3] = '{8'hAA, 8'h55, 8'h00, 1'b0, 0};
        vecs[4] = '{8'hFF, 8'h01, 8'h01, 1'b0, 5};
        vecs[5] = '{8'h5A, 8'hF3, 8'h52, 1'b1, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_y", 32'(out_y), 0);
        chk("reset_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].toggle, vecs[i].hold);
        end

        // reset in the middle of SHIFT at counter=3
        @(negedge clk);
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_y", 32'(out_y), 0);
        chk("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid || busy) saw_valid = 1;
        end
        chk("no_valid_after_reset", 32'(saw_valid), 0);
        run_op(8'hC3, 8'h81, 8'h81, 1'b0, 0);

        // back-to-back with in_valid and out_ready held high
        bb_a[0] = 8'h0F; bb_b[0] = 8'h3C; bb_y[0] = 8'h0C;
        bb_a[1] = 8'hA5; bb_b[1] = 8'hFF; bb_y[1] = 8'hA5;
        bb_a[2] = 8'h81; bb_b[2] = 8'h7E; bb_y[2] = 8'h00;
        nin  = 0;
        nout = 0;
        e    = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (nout < 3 && e < 200) begin
            if (out_valid) begin
                chk("b2b_out_y", 32'(out_y), 32'(bb_y[nout]));
                out_edge[nout] = e;
                nout++;
            end
            if (in_ready) begin
                if (nin < 3) begin
                    in_a = bb_a[nin];
                    in_b = bb_b[nin];
                    in_edge[nin] = e + 1;
                    nin++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 32'(nout), 3);
        if (nout == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("b2b_latency", 32'(out_edge[i] - in_edge[i]), W);
            end
            for (int i = 0; i < 2; i++) begin
                chk("b2b_period", 32'(in_edge[i+1] - in_edge[i]), W + 2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
